// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding a round-robin
// scheduler that drives one registered common data bus slot.
package mips_core_pkg;
  localparam int ROB_DEPTH_BITS = 5;
  localparam int DATA_WIDTH = 32;
endpackage

module cdb_arbiter
  import mips_core_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int Q_DEPTH = 2,
  parameter int TAG_W = ROB_DEPTH_BITS,
  parameter int DATA_W = DATA_WIDTH,
  localparam int SRC_BITS = $clog2(NUM_SRC > 2 ? NUM_SRC : 2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_BITS-1:0]       cdb_src,
  output logic [15:0]               conflict_cnt
);

  localparam int PTR_W = $clog2(Q_DEPTH > 1 ? Q_DEPTH : 2);
  localparam int CNT_W = $clog2(Q_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(Q_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Q_DEPTH);
  localparam logic [SRC_BITS-1:0] SRC_LAST = SRC_BITS'(NUM_SRC - 1);
  localparam logic [SRC_BITS:0] SRC_NUM = (SRC_BITS+1)'(NUM_SRC);

  logic [TAG_W-1:0]  q_tag  [NUM_SRC][Q_DEPTH];
  logic [DATA_W-1:0] q_data [NUM_SRC][Q_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr [NUM_SRC];
  logic [CNT_W-1:0]  cnt    [NUM_SRC];

  logic [SRC_BITS-1:0]  rr_ptr;
  logic [NUM_SRC-1:0]   nonempty;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [2*NUM_SRC-1:0] ne_dbl;
  logic [NUM_SRC-1:0]   ne_rot;
  logic                 grant;
  logic [SRC_BITS:0]    win_sum;
  logic [SRC_BITS-1:0]  win;
  logic                 contention;

  always_comb begin
    nonempty = '0;
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = cnt[i] != '0;
      src_ready[i] = cnt[i] < CNT_FULL;
    end
  end

  assign push = src_valid & src_ready & {NUM_SRC{~flush}};
  assign contention = |(nonempty & (nonempty - NUM_SRC'(1)));

  // rotate so bit 0 is the rr_ptr source; lowest set bit wins
  assign ne_dbl = {nonempty, nonempty};
  assign ne_rot = NUM_SRC'(ne_dbl >> rr_ptr);

  always_comb begin
    grant = 1'b0;
    win_sum = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (ne_rot[k]) begin
        grant = 1'b1;
        win_sum = {1'b0, rr_ptr} + (SRC_BITS+1)'(k);
      end
    end
    if (win_sum >= SRC_NUM)
      win_sum = win_sum - SRC_NUM;
  end

  assign win = win_sum[SRC_BITS-1:0];

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++)
      pop[i] = grant && !flush && (win == SRC_BITS'(i));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        q_tag[i][wr_ptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
        q_data[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i])
          wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0
                       : wr_ptr[i] + PTR_W'(1);
        if (pop[i])
          rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0
                       : rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (pop[i] && !push[i])
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_src <= '0;
      conflict_cnt <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= grant;
      if (grant) begin
        rr_ptr <= (win == SRC_LAST) ? '0 : win + SRC_BITS'(1);
        cdb_tag <= q_tag[win][rd_ptr[win]];
        cdb_data <= q_data[win][rd_ptr[win]];
        cdb_src <= win;
      end
      if (contention && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter
// against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  localparam int NS = 2;
  localparam int QD = 2;
  localparam int TW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [NS-1:0] src_valid = '0;
  logic [TW-1:0] d_tag [NS];
  logic [DW-1:0] d_data [NS];
  logic [NS*TW-1:0] src_tag;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0] src_ready;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [0:0] cdb_src;
  logic [15:0] conflict_cnt;

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign src_tag[g*TW +: TW] = d_tag[g];
    assign src_data[g*DW +: DW] = d_data[g];
  end

  cdb_arbiter #(
    .NUM_SRC(NS), .Q_DEPTH(QD), .TAG_W(TW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // reference model: one FIFO of {tag,data} per source
  logic [TW+DW-1:0] mq [NS][$];
  int m_rr;
  logic m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic m_src;
  int m_cnt;
  int nvec = 0;
  int nerr = 0;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_rr = 0;
    m_valid = 0;
    m_tag = '0;
    m_data = '0;
    m_src = 0;
    m_cnt = 0;
  endtask

  task automatic step();
    bit [NS-1:0] rdy;
    int ne, w, j;
    bit g;
    for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < QD);
    if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_rr = 0;
      m_valid = 0;
    end else begin
      ne = 0; g = 0; w = 0;
      for (int i = 0; i < NS; i++) if (mq[i].size() > 0) ne++;
      for (int k = 0; k < NS; k++) begin
        j = (m_rr + k) % NS;
        if (!g && mq[j].size() > 0) begin g = 1; w = j; end
      end
      if (ne >= 2 && m_cnt < 65535) m_cnt++;
      m_valid = g;
      if (g) begin
        {m_tag, m_data} = mq[w].pop_front();
        m_src = w[0];
        m_rr = (w + 1) % NS;
      end
      for (int i = 0; i < NS; i++)
        if (src_valid[i] && rdy[i]) mq[i].push_back({d_tag[i], d_data[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    src_valid = '0;
    flush = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 ||
        cdb_src !== '0 || conflict_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_vals got v=%b t=%h d=%h s=%b c=%h want all 0",
               cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt);
    end
    nvec++;
    if (src_ready !== 2'b11) begin
      nerr++; $display("FAIL reset_ready got %b want 11", src_ready);
    end
    src_valid = 2'b11;
    d_tag[0] = 8'h11; d_tag[1] = 8'h22;
    d_data[0] = 32'hA0; d_data[1] = 32'hB0;
    step();
    d_tag[0] = 8'h13; d_tag[1] = 8'h24;
    step();
    src_valid = '0;
    nvec++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 8'h11 || src_ready !== 2'b01) begin
      nerr++;
      $display("FAIL pre_reset got v=%b t=%h r=%b want 1 11 01",
               cdb_valid, cdb_tag, src_ready);
    end
    #3 rst_n = 0;
    #1;
    nvec++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 ||
        src_ready !== 2'b11) begin
      nerr++;
      $display("FAIL async_reset got v=%b t=%h d=%h r=%b want 0 0 0 11",
               cdb_valid, cdb_tag, cdb_data, src_ready);
    end
    #1 rst_n = 1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      nvec++;
      if (cdb_valid !== 1'b0) begin
        nerr++; $display("FAIL post_reset_idle c=%0d got %b want 0", c, cdb_valid);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    src_valid = 2'b01;
    d_tag[0] = 8'd5;
    d_data[0] = 32'hDEADBEEF;
    step();
    src_valid = '0;
    nvec++;
    if (cdb_valid !== 1'b0) begin
      nerr++; $display("FAIL single_c1 got v=%b want 0", cdb_valid);
    end
    step();
    nvec++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 8'd5 ||
        cdb_data !== 32'hDEADBEEF || cdb_src !== 1'b0) begin
      nerr++;
      $display("FAIL single_c2 got v=%b t=%h d=%h s=%b want 1 05 deadbeef 0",
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    step();
    nvec++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 8'd5) begin
      nerr++;
      $display("FAIL single_c3 got v=%b t=%h want 0 05", cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_simul();
    do_reset();
    src_valid = 2'b11;
    d_tag[0] = 8'd1; d_tag[1] = 8'd2;
    d_data[0] = 32'h100; d_data[1] = 32'h200;
    step();
    src_valid = '0;
    step();
    nvec++;
    if (cdb_valid !== 1'b1 || cdb_src !== 1'b0 || cdb_tag !== 8'd1) begin
      nerr++;
      $display("FAIL simul_c2 got v=%b s=%b t=%h want 1 0 01",
               cdb_valid, cdb_src, cdb_tag);
    end
    step();
    nvec++;
    if (cdb_valid !== 1'b1 || cdb_src !== 1'b1 || cdb_tag !== 8'd2 ||
        cdb_data !== 32'h200) begin
      nerr++;
      $display("FAIL simul_c3 got v=%b s=%b t=%h d=%h want 1 1 02 200",
               cdb_valid, cdb_src, cdb_tag, cdb_data);
    end
    nvec++;
    if (conflict_cnt !== 16'd1) begin
      nerr++; $display("FAIL simul_conflict got %0d want 1", conflict_cnt);
    end
  endtask

  task automatic test_sustained();
    logic [TW-1:0] nt [NS];
    logic [TW-1:0] sb [NS];
    bit [NS-1:0] rdy;
    int acc, bc, last;
    bit drop;
    do_reset();
    nt[0] = 8'h00; nt[1] = 8'h80;
    sb[0] = 8'h00; sb[1] = 8'h80;
    acc = 0; bc = 0; last = -1; drop = 0;
    for (int i = 0; i < NS; i++) d_data[i] = $urandom;
    for (int c = 0; c < 28; c++) begin
      src_valid = (c < 20) ? 2'b11 : 2'b00;
      for (int i = 0; i < NS; i++) d_tag[i] = nt[i];
      for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < QD);
      nvec++;
      if (src_ready !== rdy) begin
        nerr++; $display("FAIL sust_ready c=%0d got %b want %b", c, src_ready, rdy);
      end
      if (c < 20 && src_ready != 2'b11) drop = 1;
      step();
      for (int i = 0; i < NS; i++)
        if (src_valid[i] && rdy[i]) begin
          nt[i]++; acc++; d_data[i] = $urandom;
        end
      nvec++;
      if (cdb_valid !== m_valid || cdb_tag !== m_tag || cdb_data !== m_data) begin
        nerr++;
        $display("FAIL sust_model c=%0d got v=%b t=%h d=%h want %b %h %h",
                 c, cdb_valid, cdb_tag, cdb_data, m_valid, m_tag, m_data);
      end
      if (cdb_valid === 1'b1) begin
        bc++;
        nvec++;
        if (cdb_tag !== sb[cdb_src]) begin
          nerr++;
          $display("FAIL sust_order c=%0d src=%b got t=%h want %h",
                   c, cdb_src, cdb_tag, sb[cdb_src]);
        end
        sb[cdb_src] = cdb_tag + 8'd1;
        if (c < 20 && last >= 0) begin
          nvec++;
          if (int'(cdb_src) == last) begin
            nerr++; $display("FAIL sust_alternate c=%0d got src %0d twice", c, last);
          end
        end
        last = int'(cdb_src);
      end else begin
        last = -1;
      end
    end
    nvec++;
    if (bc != acc) begin
      nerr++; $display("FAIL sust_count got %0d broadcasts want %0d", bc, acc);
    end
    nvec++;
    if (!drop) begin
      nerr++; $display("FAIL sust_ready_drop got never-low want some low");
    end
  endtask

  task automatic test_flush();
    bit first;
    do_reset();
    src_valid = 2'b01;
    d_tag[0] = 8'd9; d_data[0] = 32'h9;
    step();
    src_valid = 2'b11;
    d_tag[0] = 8'd3; d_tag[1] = 8'd20;
    step();
    d_tag[0] = 8'd4; d_tag[1] = 8'd21;
    step();
    nvec++;
    if (src_ready !== 2'b10 || cdb_tag !== 8'd20 || cdb_src !== 1'b1) begin
      nerr++;
      $display("FAIL flush_pre got r=%b t=%h s=%b want 10 14 1",
               src_ready, cdb_tag, cdb_src);
    end
    src_valid = 2'b10;
    d_tag[1] = 8'd7;
    flush = 1;
    step();
    flush = 0;
    src_valid = '0;
    nvec++;
    if (cdb_valid !== 1'b0 || src_ready !== 2'b11) begin
      nerr++;
      $display("FAIL flush_post got v=%b r=%b want 0 11", cdb_valid, src_ready);
    end
    src_valid = 2'b11;
    d_tag[0] = 8'd31; d_tag[1] = 8'd30;
    step();
    src_valid = '0;
    first = 1;
    for (int c = 0; c < 5; c++) begin
      if (cdb_valid === 1'b1) begin
        nvec++;
        if (cdb_tag inside {8'd3, 8'd4, 8'd7, 8'd21}) begin
          nerr++; $display("FAIL flush_leak got t=%h want none of 03 04 07 15", cdb_tag);
        end
        if (first) begin
          first = 0;
          nvec++;
          if (cdb_src !== 1'b0 || cdb_tag !== 8'd31) begin
            nerr++;
            $display("FAIL flush_rr got s=%b t=%h want 0 1f", cdb_src, cdb_tag);
          end
        end
      end
      step();
    end
    nvec++;
    if (first) begin
      nerr++; $display("FAIL flush_resume got no broadcast want one");
    end
  endtask

  task automatic test_random();
    bit [NS-1:0] rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      src_valid = NS'($urandom_range(0, 3));
      for (int i = 0; i < NS; i++) begin
        d_tag[i] = TW'($urandom);
        d_data[i] = $urandom;
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < QD);
      nvec++;
      if (src_ready !== rdy) begin
        nerr++; $display("FAIL rand_ready c=%0d got %b want %b", c, src_ready, rdy);
      end
      step();
      nvec++;
      if (cdb_valid !== m_valid) begin
        nerr++; $display("FAIL rand_valid c=%0d got %b want %b", c, cdb_valid, m_valid);
      end
      nvec++;
      if (cdb_tag !== m_tag || cdb_data !== m_data || cdb_src !== m_src) begin
        nerr++;
        $display("FAIL rand_bus c=%0d got t=%h d=%h s=%b want %h %h %b",
                 c, cdb_tag, cdb_data, cdb_src, m_tag, m_data, m_src);
      end
      nvec++;
      if (conflict_cnt !== 16'(m_cnt)) begin
        nerr++; $display("FAIL rand_conflict c=%0d got %0d want %0d", c, conflict_cnt, m_cnt);
      end
    end
    flush = 0;
    src_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    src_valid = 2'b11;
    repeat (100) @(posedge clk);
    #1;
    nvec++;
    if (conflict_cnt !== 16'd99) begin
      nerr++; $display("FAIL sat_early got %0d want 99", conflict_cnt);
    end
    repeat (65440) @(posedge clk);
    #1;
    nvec++;
    if (conflict_cnt !== 16'hFFFF) begin
      nerr++; $display("FAIL sat_reach got %h want ffff", conflict_cnt);
    end
    repeat (5) @(posedge clk);
    #1;
    nvec++;
    if (conflict_cnt !== 16'hFFFF) begin
      nerr++; $display("FAIL sat_hold got %h want ffff", conflict_cnt);
    end
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    src_valid = '0;
    nvec++;
    if (conflict_cnt !== 16'hFFFF || cdb_valid !== 1'b0) begin
      nerr++;
      $display("FAIL sat_flush got c=%h v=%b want ffff 0", conflict_cnt, cdb_valid);
    end
    rst_n = 0;
    #1;
    nvec++;
    if (conflict_cnt !== 16'd0) begin
      nerr++; $display("FAIL sat_reset got %h want 0", conflict_cnt);
    end
    #1 rst_n = 1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      d_tag[i] = '0;
      d_data[i] = '0;
    end
    model_reset();
    test_reset();
    test_single();
    test_simul();
    test_sustained();
    test_flush();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
